// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw path.
package draw_pkg;

    localparam int unsigned CORDW = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/draw_sched_if.sv
// Handshake bundle between the frame scheduler and its environment.
interface draw_sched_if #(
    parameter int unsigned DROPW = 8
) ();
    logic             sched_en;
    logic             frame_start;
    logic             clear_start;
    logic             clear_done;
    logic             screen_refresh;
    logic             screen_done;
    logic             front_buf;
    logic             back_buf;
    logic             busy;
    logic [DROPW-1:0] drop_cnt;
    logic             err;

    modport master (
        input  sched_en, frame_start, clear_done, screen_done,
        output clear_start, screen_refresh, front_buf, back_buf, busy, drop_cnt, err
    );

    modport slave (
        output sched_en, frame_start, clear_done, screen_done,
        input  clear_start, screen_refresh, front_buf, back_buf, busy, drop_cnt, err
    );
endinterface

// File: rtl/draw_sched_wdog.sv
// Phase watchdog: counts cycles spent in CLEAR or DRAW and flags the limit.
module sched_wdog #(
    parameter int unsigned     TOW     = 24,
    parameter logic [TOW-1:0]  TIMEOUT = TOW'(2_000_000)
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart_i,
    input  logic run_i,
    output logic timeout_c
);
    logic [TOW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + TOW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the TIMEOUT-th cycle of a phase.
    assign timeout_c = run_i && (cnt_q == (TIMEOUT - TOW'(1)));
endmodule

// File: rtl/draw_sched.sv
// Per-frame clear/draw/swap sequencer with double-buffer select and drop counter.
// Optional watchdog abort enabled by defining SCHED_WDOG_EN.
module draw_sched
    import draw_pkg::*;
#(
    parameter int unsigned    DROPW   = 8,
    parameter int unsigned    TOW     = 24,
    parameter logic [TOW-1:0] TIMEOUT = TOW'(2_000_000)
) (
    input  logic           clk,
    input  logic           rstn,
    draw_sched_if.master   bus
);
    sched_state_t     state_q, state_d;
    logic             front_q, front_d;
    logic             back_q;
    logic             fresh_q, fresh_d;
    logic             clear_start_q, clear_start_d;
    logic             refresh_q, refresh_d;
    logic             busy_q;
    logic [DROPW-1:0] drop_q, drop_d;
    logic             err_q, err_d;
    logic             timeout_c;

`ifdef SCHED_WDOG_EN
    logic restart_c;
    assign restart_c = (state_d != state_q) && (state_d != IDLE);

    sched_wdog #(
        .TOW     (TOW),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rstn      (rstn),
        .restart_i (restart_c),
        .run_i     (state_q != IDLE),
        .timeout_c (timeout_c)
    );
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^{TIMEOUT, TOW[0]};
    assign timeout_c       = 1'b0;
`endif

    // Next-state and output decode; a real done pulse wins over a timeout.
    always_comb begin
        state_d       = state_q;
        front_d       = front_q;
        fresh_d       = fresh_q;
        clear_start_d = 1'b0;
        refresh_d     = 1'b0;
        drop_d        = drop_q;
        err_d         = err_q;

        if ((state_q != IDLE) && bus.frame_start && (drop_q != '1)) begin
            drop_d = drop_q + DROPW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.frame_start && bus.sched_en) begin
                    if (fresh_q) begin
                        front_d = ~front_q;
                        fresh_d = 1'b0;
                    end
                    clear_start_d = 1'b1;
                    state_d       = CLEAR;
                end
            end
            CLEAR: begin
                if (bus.clear_done) begin
                    refresh_d = 1'b1;
                    state_d   = DRAW;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAW: begin
                if (bus.screen_done) begin
                    fresh_d = 1'b1;
                    state_d = IDLE;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            front_q       <= 1'b0;
            back_q        <= 1'b1;
            fresh_q       <= 1'b0;
            clear_start_q <= 1'b0;
            refresh_q     <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            front_q       <= front_d;
            back_q        <= ~front_d;
            fresh_q       <= fresh_d;
            clear_start_q <= clear_start_d;
            refresh_q     <= refresh_d;
            busy_q        <= (state_d != IDLE);
            drop_q        <= drop_d;
            err_q         <= err_d;
        end
    end

    assign bus.clear_start    = clear_start_q;
    assign bus.screen_refresh = refresh_q;
    assign bus.front_buf      = front_q;
    assign bus.back_buf       = back_q;
    assign bus.busy           = busy_q;
    assign bus.drop_cnt       = drop_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_draw_sched.sv
// Self-checking bench for draw_sched: directed frame scenarios plus random traffic vs. a job-level model.
module tb_draw_sched;
`ifdef SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
    localparam int TMO  = 100;
`else
    localparam bit WDOG = 1'b0;
    localparam int TMO  = 2_000_000;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    draw_sched_if #(.DROPW(8)) bus ();

    draw_sched #(
        .DROPW   (8),
        .TOW     (24),
        .TIMEOUT (24'(TMO))
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Model: a job is either absent or in its clear/draw phase.
    bit job_on, job_drawing, have_frame, m_front, m_err, m_cs, m_rf;
    int m_drop, phase_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        job_on = 0; job_drawing = 0; have_frame = 0; m_front = 0;
        m_err = 0; m_cs = 0; m_rf = 0; m_drop = 0; phase_cycles = 0;
    endtask

    task automatic model_cycle(input bit fs, input bit en, input bit cd, input bit sd);
        m_cs = 0;
        m_rf = 0;
        if (!job_on) begin
            if (fs && en) begin
                if (have_frame) begin
                    m_front    = !m_front;
                    have_frame = 0;
                end
                m_cs = 1; job_on = 1; job_drawing = 0; phase_cycles = 0;
            end
        end else begin
            if (fs) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            if (!job_drawing && cd) begin
                m_rf = 1; job_drawing = 1; phase_cycles = 0;
            end else if (job_drawing && sd) begin
                have_frame = 1; job_on = 0;
            end else if (WDOG && phase_cycles == TMO - 1) begin
                job_on = 0; m_err = 1;
            end else begin
                phase_cycles++;
            end
        end
    endtask

    task automatic compare_all();
        check("clear_start",    32'(bus.clear_start),    32'(m_cs));
        check("screen_refresh", 32'(bus.screen_refresh), 32'(m_rf));
        check("front_buf",      32'(bus.front_buf),      32'(m_front));
        check("back_buf",       32'(bus.back_buf),       32'(!m_front));
        check("busy",           32'(bus.busy),           32'(job_on));
        check("drop_cnt",       32'(bus.drop_cnt),       32'(m_drop));
        check("err",            32'(bus.err),            32'(m_err));
    endtask

    // One clock: inputs currently on the bus are sampled, then outputs checked #1 after the edge.
    task automatic cyc(input bit fs, input bit cd, input bit sd);
        bit en;
        bus.frame_start = fs;
        bus.clear_done  = cd;
        bus.screen_done = sd;
        en = bus.sched_en;
        @(posedge clk);
        #1;
        model_cycle(fs, en, cd, sd);
        compare_all();
        bus.frame_start = 0;
        bus.clear_done  = 0;
        bus.screen_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        bus.sched_en    = 1;
        bus.frame_start = 0;
        bus.clear_done  = 0;
        bus.screen_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rstn = 1;

        // First frame: no completed frame yet, so no swap.
        idle(9);
        cyc(1, 0, 0);
        check("first_clear_start", 32'(bus.clear_start), 32'd1);
        idle(1);
        check("clear_start_one_cycle", 32'(bus.clear_start), 32'd0);
        idle(7);
        cyc(0, 1, 0);
        check("first_refresh", 32'(bus.screen_refresh), 32'd1);
        idle(19);
        cyc(0, 0, 1);
        check("busy_drop_after_done", 32'(bus.busy), 32'd0);
        check("front_no_swap_yet", 32'(bus.front_buf), 32'd0);

        // Second frame swaps in the finished buffer.
        idle(3);
        cyc(1, 0, 0);
        check("swap_front", 32'(bus.front_buf), 32'd1);
        check("swap_back", 32'(bus.back_buf), 32'd0);
        idle(2);
        cyc(0, 1, 0);
        idle(2);

        // Three overruns during DRAW.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            idle(1);
        end
        check("drop_three", 32'(bus.drop_cnt), 32'd3);
        check("no_swap_on_drop", 32'(bus.front_buf), 32'd1);
        cyc(0, 0, 1);
        idle(2);
        cyc(1, 0, 0);
        check("swap_after_overrun", 32'(bus.front_buf), 32'd0);

        // Frame start coincident with screen_done.
        cyc(0, 1, 0);
        idle(3);
        cyc(1, 0, 1);
        check("coincident_drop", 32'(bus.drop_cnt), 32'd4);
        check("coincident_idle", 32'(bus.busy), 32'd0);
        idle(1);
        cyc(1, 0, 0);
        check("coincident_swap", 32'(bus.front_buf), 32'd1);

        // Saturate the drop counter while in CLEAR.
        for (int i = 0; i < 260; i++) cyc(1, 0, 0);
        check("drop_saturated", 32'(bus.drop_cnt), 32'd255);
        cyc(1, 1, 0);
        check("drop_stays_sat", 32'(bus.drop_cnt), 32'd255);
        cyc(0, 0, 1);
        idle(2);

        // Disabled scheduler ignores frame_start.
        bus.sched_en = 0;
        cyc(1, 0, 0);
        check("disabled_no_start", 32'(bus.clear_start), 32'd0);
        check("disabled_not_busy", 32'(bus.busy), 32'd0);
        idle(2);
        bus.sched_en = 1;

        // Asynchronous reset in the middle of DRAW.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(4);
        #2 rstn = 0;
        #1;
        model_reset();
        compare_all();
        #2 rstn = 1;
        idle(2);

`ifdef SCHED_WDOG_EN
        // Withheld screen_done trips the watchdog after TMO cycles of DRAW.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        idle(TMO - 1);
        check("wdog_not_yet", 32'(bus.err), 32'd0);
        idle(1);
        check("wdog_err", 32'(bus.err), 32'd1);
        check("wdog_idle", 32'(bus.busy), 32'd0);
        check("wdog_front_kept", 32'(bus.front_buf), 32'd0);
        idle(2);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.sched_en = ($urandom_range(0, 9) != 0);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 14) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
